// File: rtl/calc_entry_fsm_if.sv
// Purpose : bundles the calculator front-end buttons, ALU handshake and strobes.
// Latency : none, wiring only.
// Backpressure: none; alu_done is the only return path from the ALU.
// Ports   : slave  = sequencer side (buttons/op_sel/alu_done in, strobes/status out)
//           master = environment side (drives buttons/op_sel/alu_done, observes strobes)
interface calc_entry_fsm_if #(
    parameter int OP_W = 2
);
    logic            btn_enter;
    logic            btn_clear;
    logic [OP_W-1:0] op_sel;
    logic            alu_done;
    logic            load_a;
    logic            load_b;
    logic            start;
    logic [OP_W-1:0] op_code;
    logic            busy;
    logic [2:0]      state_out;

    modport slave (
        input  btn_enter, btn_clear, op_sel, alu_done,
        output load_a, load_b, start, op_code, busy, state_out
    );

    modport master (
        output btn_enter, btn_clear, op_sel, alu_done,
        input  load_a, load_b, start, op_code, busy, state_out
    );
endinterface

// File: rtl/calc_entry_fsm.sv
// Purpose : debounces ENTER/CLEAR and sequences operand A, operand B, operator entry and ALU start.
// Latency : strobe is high the cycle after edge k+DEBOUNCE_CYCLES+3 when btn_enter rises at edge k.
// Backpressure: waits in EXEC until alu_done; button events arriving there (except CLEAR) are dropped.
// Ports   : clk, reset (async active-low); bus (slave modport) carries buttons, op_sel,
//           alu_done, load_a/load_b/start strobes, op_code, busy and state_out.
module calc_entry_fsm #(
    parameter int DEBOUNCE_CYCLES = 1000000,  // must be >= 2
    parameter int OP_W            = 2
) (
    input  logic            clk,
    input  logic            reset,
    calc_entry_fsm_if.slave bus
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    // Toggling on the increment that would reach DEBOUNCE_CYCLES means the
    // level changes after exactly DEBOUNCE_CYCLES consecutive mismatching cycles.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam int BTN_ENTER = 0;
    localparam int BTN_CLEAR = 1;

    typedef enum logic [2:0] {
        ST_GET_A  = 3'd0,
        ST_GET_B  = 3'd1,
        ST_GET_OP = 3'd2,
        ST_EXEC   = 3'd3,
        ST_SHOW   = 3'd4
    } state_t;

    // ---------------- button conditioning (bit 0 = ENTER, bit 1 = CLEAR)
    logic [1:0]       sync1_q, sync1_d;
    logic [1:0]       sync2_q, sync2_d;
    logic [1:0]       deb_q, deb_d;
    logic [1:0]       deb_dly_q, deb_dly_d;
    logic [1:0]       ev_q, ev_d;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];

    always_comb begin
        sync1_d   = {bus.btn_clear, bus.btn_enter};
        sync2_d   = sync1_q;
        deb_d     = deb_q;
        deb_dly_d = deb_q;
        // One-cycle event on the debounced rising edge only; releases are silent.
        ev_d      = deb_q & ~deb_dly_q;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    deb_d[i] = ~deb_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            deb_q     <= '0;
            deb_dly_q <= '0;
            ev_q      <= '0;
            for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            deb_q     <= deb_d;
            deb_dly_q <= deb_dly_d;
            ev_q      <= ev_d;
            for (int i = 0; i < 2; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // ---------------- entry sequencer
    state_t          state_q, state_d;
    logic            load_a_q, load_a_d;
    logic            load_b_q, load_b_d;
    logic            start_q, start_d;
    logic [OP_W-1:0] op_code_q, op_code_d;

    logic ev_e;
    logic ev_c;
    assign ev_e = ev_q[BTN_ENTER];
    assign ev_c = ev_q[BTN_CLEAR];

    always_comb begin
        state_d   = state_q;
        load_a_d  = 1'b0;
        load_b_d  = 1'b0;
        start_d   = 1'b0;
        op_code_d = op_code_q;
        if (ev_c) begin
            // Clear beats a simultaneous enter and abandons any ALU work.
            state_d   = ST_GET_A;
            op_code_d = '0;
        end else begin
            unique case (state_q)
                ST_GET_A: if (ev_e) begin
                    load_a_d = 1'b1;
                    state_d  = ST_GET_B;
                end
                ST_GET_B: if (ev_e) begin
                    load_b_d = 1'b1;
                    state_d  = ST_GET_OP;
                end
                ST_GET_OP: if (ev_e) begin
                    op_code_d = bus.op_sel;
                    start_d   = 1'b1;
                    state_d   = ST_EXEC;
                end
                // The start strobe cycle already shows EXEC; a done pulse
                // coincident with start cannot belong to this operation.
                ST_EXEC: if (bus.alu_done && !start_q) begin
                    state_d = ST_SHOW;
                end
                ST_SHOW: if (ev_e) begin
                    state_d = ST_GET_A;
                end
                default: state_d = ST_GET_A;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_GET_A;
            load_a_q  <= 1'b0;
            load_b_q  <= 1'b0;
            start_q   <= 1'b0;
            op_code_q <= '0;
        end else begin
            state_q   <= state_d;
            load_a_q  <= load_a_d;
            load_b_q  <= load_b_d;
            start_q   <= start_d;
            op_code_q <= op_code_d;
        end
    end

    assign bus.load_a    = load_a_q;
    assign bus.load_b    = load_b_q;
    assign bus.start     = start_q;
    assign bus.op_code   = op_code_q;
    assign bus.busy      = (state_q == ST_EXEC);
    assign bus.state_out = state_q;
endmodule

// File: tb/tb_calc_entry_fsm.sv
// Bench for calc_entry_fsm with a short debounce window.
// Every cycle the outputs are compared with a reference model that works from
// raw button history windows; table rows and hand sequences add fixed expectations.
module tb_calc_entry_fsm;
    localparam int D = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    calc_entry_fsm_if #(.OP_W(2)) bus();

    calc_entry_fsm #(.DEBOUNCE_CYCLES(D), .OP_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // ---------------- reference model
    bit         ring [2][64];   // raw samples per button, indexed by edge number
    int         m_n;
    bit         m_lvl [2];
    bit         m_rose [2];
    bit         m_ev [2];
    int         m_state;
    logic [1:0] m_op;
    bit         m_la, m_lb, m_st;
    int         m_age;          // edges spent in EXEC since entering it

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 64; j++) ring[i][j] = 1'b0;
            m_lvl[i] = 1'b0; m_rose[i] = 1'b0; m_ev[i] = 1'b0;
        end
        m_n = 0; m_state = 0; m_op = 2'b00;
        m_la = 1'b0; m_lb = 1'b0; m_st = 1'b0; m_age = 0;
    endtask

    // Advances the model across one rising edge using the inputs about to be sampled.
    task automatic model_edge();
        bit nla, nlb, nst, all_diff;
        int nstate, nage;
        logic [1:0] nop;
        bit nlvl [2];
        bit nrose [2];
        bit nev [2];
        nla = 1'b0; nlb = 1'b0; nst = 1'b0;
        nstate = m_state; nop = m_op;
        if (m_ev[1]) begin
            nstate = 0; nop = 2'b00;
        end else begin
            case (m_state)
                0: if (m_ev[0]) begin nla = 1'b1; nstate = 1; end
                1: if (m_ev[0]) begin nlb = 1'b1; nstate = 2; end
                2: if (m_ev[0]) begin nop = bus.op_sel; nst = 1'b1; nstate = 3; end
                3: if (bus.alu_done && m_age > 0) nstate = 4;
                4: if (m_ev[0]) nstate = 0;
                default: nstate = 0;
            endcase
        end
        nage = (nstate == 3 && m_state == 3) ? m_age + 1 : 0;
        for (int i = 0; i < 2; i++) begin
            nev[i] = m_rose[i];
            // Synchronised value lags the raw sample by two edges; the level
            // flips once D consecutive synchronised samples disagree with it.
            all_diff = 1'b1;
            for (int j = 2; j <= D + 1; j++)
                if (ring[i][(m_n - j) & 63] == m_lvl[i]) all_diff = 1'b0;
            nlvl[i]  = all_diff ? !m_lvl[i] : m_lvl[i];
            nrose[i] = all_diff && !m_lvl[i];
        end
        for (int i = 0; i < 2; i++) begin
            m_lvl[i] = nlvl[i]; m_rose[i] = nrose[i]; m_ev[i] = nev[i];
        end
        m_la = nla; m_lb = nlb; m_st = nst;
        m_state = nstate; m_op = nop; m_age = nage;
        ring[0][m_n & 63] = bus.btn_enter;
        ring[1][m_n & 63] = bus.btn_clear;
        m_n++;
    endtask

    function automatic int model_vec();
        logic [2:0] s;
        s = 3'(m_state);
        return int'({m_la, m_lb, m_st, m_op, (m_state == 3), s});
    endfunction

    function automatic int dut_vec();
        return int'({bus.load_a, bus.load_b, bus.start, bus.op_code, bus.busy, bus.state_out});
    endfunction

    task automatic check_eq(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_eq(tag, dut_vec(), model_vec());
    endtask

    task automatic press(input bit is_clear, input int hold);
        if (is_clear) bus.btn_clear = 1'b1; else bus.btn_enter = 1'b1;
        repeat (hold) step("press");
        bus.btn_clear = 1'b0;
        bus.btn_enter = 1'b0;
        repeat (10) step("release");
    endtask

    // ---------------- table of input levels and expected outcomes
    typedef struct {
        bit         en;
        bit         cl;
        logic [1:0] op;
        bit         done;
        int         hold;
        int         exp_state;
        int         exp_la;
        int         exp_lb;
        int         exp_st;
        logic [1:0] exp_op;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int la_cnt, lb_cnt, st_cnt, e_left, c_left;
        bit found;

        bus.btn_enter = 1'b0;
        bus.btn_clear = 1'b0;
        bus.op_sel    = 2'b00;
        bus.alu_done  = 1'b0;

        // Reset held for three cycles: everything quiet.
        repeat (3) begin
            @(posedge clk);
            #1;
            check_eq("reset_outputs", dut_vec(), 0);
        end
        model_reset();
        reset = 1'b1;
        repeat (20) step("idle");

        // Full walk, glitch rejection and bounce filtering.
        tbl.push_back('{1, 0, 2'd0, 0, 10, 1, 1, 0, 0, 2'd0});
        tbl.push_back('{0, 0, 2'd0, 0, 10, 1, 0, 0, 0, 2'd0});
        tbl.push_back('{1, 0, 2'd0, 0, 10, 2, 0, 1, 0, 2'd0});
        tbl.push_back('{0, 0, 2'd0, 0, 10, 2, 0, 0, 0, 2'd0});
        tbl.push_back('{1, 0, 2'd2, 0, 10, 3, 0, 0, 1, 2'd2});
        tbl.push_back('{0, 0, 2'd2, 0, 10, 3, 0, 0, 0, 2'd2});
        tbl.push_back('{0, 0, 2'd2, 1,  1, 4, 0, 0, 0, 2'd2});
        tbl.push_back('{0, 0, 2'd2, 0,  5, 4, 0, 0, 0, 2'd2});
        tbl.push_back('{1, 0, 2'd2, 0, 10, 0, 0, 0, 0, 2'd2});
        tbl.push_back('{0, 0, 2'd2, 0, 10, 0, 0, 0, 0, 2'd2});
        tbl.push_back('{1, 0, 2'd2, 0,  3, 0, 0, 0, 0, 2'd2});
        tbl.push_back('{0, 0, 2'd2, 0, 10, 0, 0, 0, 0, 2'd2});
        tbl.push_back('{1, 0, 2'd2, 0,  1, 0, 0, 0, 0, 2'd2});
        tbl.push_back('{0, 0, 2'd2, 0,  1, 0, 0, 0, 0, 2'd2});
        tbl.push_back('{1, 0, 2'd2, 0,  2, 0, 0, 0, 0, 2'd2});
        tbl.push_back('{0, 0, 2'd2, 0,  1, 0, 0, 0, 0, 2'd2});
        tbl.push_back('{1, 0, 2'd2, 0,  1, 0, 0, 0, 0, 2'd2});
        tbl.push_back('{1, 0, 2'd2, 0,  6, 0, 0, 0, 0, 2'd2});
        tbl.push_back('{0, 0, 2'd2, 0, 12, 1, 1, 0, 0, 2'd2});

        foreach (tbl[r]) begin
            bus.btn_enter = tbl[r].en;
            bus.btn_clear = tbl[r].cl;
            bus.op_sel    = tbl[r].op;
            bus.alu_done  = tbl[r].done;
            la_cnt = 0; lb_cnt = 0; st_cnt = 0;
            repeat (tbl[r].hold) begin
                step($sformatf("row%0d_cycle", r));
                la_cnt += int'(bus.load_a);
                lb_cnt += int'(bus.load_b);
                st_cnt += int'(bus.start);
            end
            check_eq($sformatf("row%0d_state", r), int'(bus.state_out), tbl[r].exp_state);
            check_eq($sformatf("row%0d_op_code", r), int'(bus.op_code), int'(tbl[r].exp_op));
            check_eq($sformatf("row%0d_strobes", r), la_cnt * 100 + lb_cnt * 10 + st_cnt,
                     tbl[r].exp_la * 100 + tbl[r].exp_lb * 10 + tbl[r].exp_st);
        end
        bus.alu_done = 1'b0;

        // ENTER and CLEAR together in GET_B: clear wins, no load_b.
        bus.btn_enter = 1'b1;
        bus.btn_clear = 1'b1;
        lb_cnt = 0;
        repeat (10) begin step("coincide"); lb_cnt += int'(bus.load_b); end
        bus.btn_enter = 1'b0;
        bus.btn_clear = 1'b0;
        repeat (10) begin step("coincide_rel"); lb_cnt += int'(bus.load_b); end
        check_eq("coincide_no_load_b", lb_cnt, 0);
        check_eq("coincide_state", int'(bus.state_out), 0);
        check_eq("coincide_op_code", int'(bus.op_code), 0);

        // CLEAR while the ALU is busy, then a stale alu_done.
        bus.op_sel = 2'b11;
        press(1'b0, 10);
        press(1'b0, 10);
        press(1'b0, 10);
        check_eq("exec_state", int'(bus.state_out), 3);
        check_eq("exec_op_code", int'(bus.op_code), 3);
        check_eq("exec_busy", int'(bus.busy), 1);
        press(1'b1, 10);
        check_eq("clear_state", int'(bus.state_out), 0);
        check_eq("clear_op_code", int'(bus.op_code), 0);
        check_eq("clear_busy", int'(bus.busy), 0);
        bus.alu_done = 1'b1;
        step("stale_done");
        bus.alu_done = 1'b0;
        repeat (5) step("stale_done_after");
        check_eq("stale_done_state", int'(bus.state_out), 0);

        // Random button activity against the model.
        e_left = 0; c_left = 0;
        for (int c = 0; c < 1500; c++) begin
            if (e_left == 0) begin
                bus.btn_enter = 1'($urandom_range(0, 1));
                e_left = $urandom_range(1, 10);
            end
            if (c_left == 0) begin
                bus.btn_clear = ($urandom_range(0, 5) == 0);
                c_left = $urandom_range(1, 10);
            end
            e_left--; c_left--;
            bus.alu_done = ($urandom_range(0, 7) == 0);
            bus.op_sel   = 2'($urandom_range(0, 3));
            step("random");
        end
        bus.btn_enter = 1'b0;
        bus.btn_clear = 1'b0;
        bus.alu_done  = 1'b0;
        repeat (20) step("settle");
        press(1'b1, 10);
        check_eq("settle_state", int'(bus.state_out), 0);

        // Reset asserted while load_a is high must drop it immediately.
        bus.btn_enter = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step("arst_wait");
            if (bus.load_a) found = 1'b1;
        end
        check_eq("arst_load_a_seen", int'(found), 1);
        #2 reset = 1'b0;
        #1;
        check_eq("arst_load_a_drop", int'(bus.load_a), 0);
        check_eq("arst_state", int'(bus.state_out), 0);
        bus.btn_enter = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("arst_held", dut_vec(), 0);
        model_reset();
        reset = 1'b1;
        repeat (10) step("post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
